if_fetch_stage: RTL and testbench
=================================

# if_fetch_stage

- Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register.
- Owns the program counter and issues one instruction-memory request at a time.
- Buffers the returned instruction together with its PC and PC+4.
- Drives the IF/ID register's load and flush controls, honouring stalls from the hazard unit and redirects from branch/jump resolution.

## Interface
Parameters:
- XLEN, 32, address/data width
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INST, 32'h0000_0013, instruction presented when no valid fetch (addi x0,x0,0)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- stall  in  1  hazard unit holds IF/ID and the fetch buffer
- redirect_valid  in  1  one-cycle pulse, taken branch/jump resolved downstream
- redirect_pc  in  XLEN  target address for redirect
- imem_req  out  1  fetch request
- imem_addr  out  XLEN  fetch address; stable while imem_req=1
- imem_rvalid  in  1  read data valid; ends the request
- imem_rdata  in  XLEN  instruction word
- if_pc  out  XLEN  PC of buffered instruction
- if_pc4  out  XLEN  if_pc+4
- if_inst  out  XLEN  buffered instruction, NOP_INST when if_valid=0
- if_valid  out  1  buffer holds a live instruction
- ifid_load  out  1  IF/ID register captures if_* this cycle
- ifid_flush  out  1  IF/ID register loads its default (NOP) this cycle

## Operation
- Registers: pc, buffer (if_pc, if_inst, if_valid), FSM state.
- States:
  - IDLE: no request outstanding.
  - REQ: request outstanding, result wanted.
  - DROP: request outstanding, result to be discarded.
- IDLE → REQ: when the buffer is empty or consumed this cycle (ifid_load=1) and redirect_valid=0. imem_req=1, imem_addr=pc.
- REQ + imem_rvalid, no redirect:
  - Buffer ← {pc, imem_rdata}, if_valid ← 1, pc ← pc+4.
  - Next state is REQ again if the buffer is consumed the same cycle, otherwise IDLE.
- REQ, no rvalid: hold imem_req/imem_addr.
- Buffer consumption: ifid_load = if_valid & ~stall & ~redirect_valid.
- Redirect (any state), the same cycle:
  - pc ← redirect_pc, if_valid ← 0, ifid_flush=1, ifid_load=0.
  - If REQ without rvalid → DROP.
  - If rvalid arrives in the same cycle, the data is discarded and the next state is IDLE.
- DROP:
  - Keep imem_req=1 with the old address until imem_rvalid, then discard the data → IDLE.
  - A further redirect in DROP only updates pc.
- Priority: redirect > stall > normal fetch.
- pc+4 wraps modulo 2^XLEN with no error.

## Timing
- Reset (rst=0) values:
  - pc=RESET_PC, state=IDLE.
  - imem_req=0, imem_addr=RESET_PC.
  - if_valid=0, if_inst=NOP_INST, if_pc=RESET_PC, if_pc4=RESET_PC+4.
  - ifid_load=0, ifid_flush=0.
- Reset takes effect immediately. Any outstanding memory response after reset is ignored: state is IDLE, and rvalid in IDLE is ignored.
- First imem_req is asserted in the first cycle after rst deasserts.
- Latency with 1-cycle memory: req in cycle N, rvalid in cycle N+1, if_valid=1 in cycle N+2.
- Steady-state throughput: one instruction per 2 cycles with 1-cycle memory; the next request overlaps buffer consumption.
- ifid_load and ifid_flush are combinational from registered state and inputs. They are never both 1.

## Configuration
- FETCH_PERF_CNT_EN:
  - Defined: adds outputs perf_fetched (32-bit, +1 per accepted rvalid in REQ), perf_stall (32-bit, +1 per cycle with if_valid & stall) and perf_dropped (32-bit, +1 per discarded response).
  - All three counters reset to 0 and wrap.
  - Undefined: no counters and no ports.

## Structure
- Shared package:
  - FSM state encoding (IDLE=2'd0, REQ=2'd1, DROP=2'd2).
  - NOP_INST constant.
  - XLEN default.
- One sub-module: fetch_buffer (pc/inst/valid holding register with load, clear and async active-low reset).
- The FSM and pc live in the top module.

## Test plan
- Reset release, memory returns 32'h00500093 after 1 cycle:
  - imem_addr=0 at cycle 1.
  - Cycle 3: if_inst=32'h00500093, if_pc=0, if_pc4=4, ifid_load=1.
- Sequential fetch with stall held 3 cycles:
  - Buffer and if_* hold, ifid_load=0, no new imem_req while the buffer is full.
  - Fetch resumes at pc+4 after the stall releases.
- Redirect to 32'h0000_0100 while REQ with no rvalid:
  - State=DROP, ifid_flush=1.
  - The old response is discarded.
  - Next imem_addr=32'h100.
- Redirect in the same cycle as rvalid:
  - Data discarded, if_valid=0.
  - Next request to redirect_pc; no DROP.
- Redirect and stall together:
  - Flush wins, ifid_load=0, pc=redirect_pc.
- rst asserted mid-REQ:
  - All outputs take reset values immediately.
  - A late rvalid is ignored.
  - Fetch restarts at RESET_PC.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// rtl/if_fetch_stage_pkg.sv - shared fetch-stage FSM encoding and default constants
package if_fetch_stage_pkg;

    localparam int          PKG_XLEN     = 32;
    localparam logic [31:0] PKG_NOP_INST = 32'h0000_0013;  // addi x0,x0,0

    // IDLE: nothing outstanding; REQ: response wanted; DROP: response to be discarded
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_fetch_stage_fetch_buffer.sv
// rtl/if_fetch_stage_fetch_buffer.sv - holding register for one fetched instruction and its pc
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   load              capture load_pc/load_inst and mark the entry valid
//   clear             invalidate the entry (wins over load)
//   load_pc/load_inst data captured on load
//   buf_pc/buf_inst   held pc and instruction word
//   buf_valid         entry holds a live instruction
module fetch_buffer
    import if_fetch_stage_pkg::*;
#(
    parameter int              XLEN     = PKG_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] NOP_INST = XLEN'(PKG_NOP_INST)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            clear,
    input  logic [XLEN-1:0] load_pc,
    input  logic [XLEN-1:0] load_inst,
    output logic [XLEN-1:0] buf_pc,
    output logic [XLEN-1:0] buf_inst,
    output logic            buf_valid
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_pc    <= RESET_PC;
            buf_inst  <= NOP_INST;
            buf_valid <= 1'b0;
        end else if (clear) begin
            buf_valid <= 1'b0;
        end else if (load) begin
            buf_pc    <= load_pc;
            buf_inst  <= load_inst;
            buf_valid <= 1'b1;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction-fetch stage: pc, single-outstanding imem request, IF/ID controls
//
// Optional feature macro: FETCH_PERF_CNT_EN (adds perf_fetched, perf_stall, perf_dropped).
//
// Ports:
//   clk, rst                   rising-edge clock, asynchronous active-low reset
//   stall                      hazard unit holds IF/ID and the fetch buffer
//   redirect_valid/pc          one-cycle redirect to a new fetch address
//   imem_req/addr              fetch request, address stable while outstanding
//   imem_rvalid/rdata          response; rvalid ends the request
//   if_pc/if_pc4/if_inst       buffered instruction, pc and pc+4 (NOP when empty)
//   if_valid                   buffer holds a live instruction
//   ifid_load/ifid_flush       IF/ID capture and flush controls
//   perf_* (optional)          fetched / stalled-cycle / dropped-response counters
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter int              XLEN     = PKG_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] NOP_INST = XLEN'(PKG_NOP_INST)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pc4,
    output logic [XLEN-1:0] if_inst,
    output logic            if_valid,
    output logic            ifid_load,
    output logic            ifid_flush
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_stall,
    output logic [31:0]     perf_dropped
`endif
);

    fetch_state_t    state, state_next;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] buf_pc, buf_inst;
    logic            buf_valid;
    logic            consume;
    logic            fill;
    logic            req_raw;

    assign consume = buf_valid & ~stall & ~redirect_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The IDLE request is issued in the same cycle the buffer frees up, so the
    // next fetch overlaps consumption of the current one.
    always_comb begin
        state_next = state;
        req_raw    = 1'b0;
        fill       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!redirect_valid && (!buf_valid || consume)) begin
                    req_raw    = 1'b1;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                req_raw = 1'b1;
                if (redirect_valid) begin
                    state_next = imem_rvalid ? ST_IDLE : ST_DROP;
                end else if (imem_rvalid) begin
                    fill       = 1'b1;
                    state_next = consume ? ST_REQ : ST_IDLE;
                end
            end
            ST_DROP: begin
                req_raw = 1'b1;
                if (imem_rvalid) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // IDLE with an empty buffer would otherwise request while reset is held.
    assign imem_req   = req_raw & rst;
    assign ifid_load  = consume;
    assign ifid_flush = redirect_valid & rst;

    // A redirect while a request is in flight moves pc on, but the memory
    // still sees the original address until its response arrives.
    assign imem_addr = (state == ST_DROP) ? req_addr : pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            if (redirect_valid) begin
                pc <= redirect_pc;
            end else if (fill) begin
                pc <= pc + XLEN'(4);
            end
            if (state != ST_DROP) begin
                req_addr <= pc;
            end
        end
    end

    fetch_buffer #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP_INST)
    ) u_fetch_buffer (
        .clk       (clk),
        .rst       (rst),
        .load      (fill),
        .clear     (redirect_valid | (consume & ~fill)),
        .load_pc   (pc),
        .load_inst (imem_rdata),
        .buf_pc    (buf_pc),
        .buf_inst  (buf_inst),
        .buf_valid (buf_valid)
    );

    assign if_pc    = buf_pc;
    assign if_pc4   = buf_pc + XLEN'(4);
    assign if_inst  = buf_valid ? buf_inst : NOP_INST;
    assign if_valid = buf_valid;

`ifdef FETCH_PERF_CNT_EN
    logic drop_rsp;

    assign drop_rsp = imem_rvalid &
                      ((state == ST_DROP) || ((state == ST_REQ) && redirect_valid));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
            perf_dropped <= '0;
        end else begin
            if (fill) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (buf_valid && stall) begin
                perf_stall <= perf_stall + 32'd1;
            end
            if (drop_rsp) begin
                perf_dropped <= perf_dropped + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - scoreboard bench for if_fetch_stage with a latency-varying memory model
module tb_if_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] if_pc, if_pc4, if_inst;
    logic        if_valid, ifid_load, ifid_flush;

    if_fetch_stage #(
        .XLEN     (32),
        .RESET_PC (RST_PC),
        .NOP_INST (NOP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_pc          (if_pc),
        .if_pc4         (if_pc4),
        .if_inst        (if_inst),
        .if_valid       (if_valid),
        .ifid_load      (ifid_load),
        .ifid_flush     (ifid_flush)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          delivered = 0;
    logic [31:0] exp_q[$];

    bit          rel = 1'b0;
    bit          pend = 1'b0;
    logic [31:0] pend_addr = '0;
    int          pend_age = 0;
    int          lat = 1;
    bit          rand_lat = 1'b0;
    bit          force_rv = 1'b0;

    // Instruction memory contents: every address holds a distinct word, address 0 holds 0x00500093.
    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'h0050_0093 ^ (a * 32'h9E37_79B1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // One clock cycle: apply inputs at the falling edge, answer / track the memory request.
    task automatic cyc(input bit s, input bit r, input logic [31:0] rpc);
        @(negedge clk);
        rst            = rel;
        stall          = s;
        redirect_valid = r;
        redirect_pc    = rpc;
        if (!rel) begin
            pend = 1'b0;
        end
        if (r) begin
            exp_q.delete();
            exp_q.push_back(rpc);
        end
        imem_rvalid = force_rv | (pend && pend_age >= lat);
        imem_rdata  = force_rv ? 32'hDEAD_BEEF : word(pend_addr);
        #1;
        if (imem_rvalid && !force_rv) begin
            check("req_held_at_rvalid", 32'(imem_req), 1);
            pend = 1'b0;
        end else if (pend) begin
            check("req_held", 32'(imem_req), 1);
            check("addr_stable", imem_addr, pend_addr);
        end else if (imem_req) begin
            pend      = 1'b1;
            pend_addr = imem_addr;
            pend_age  = 0;
            if (rand_lat) begin
                lat = $urandom_range(1, 3);
            end
        end
        if (pend) begin
            pend_age++;
        end
    endtask

    // Monitor: every IF/ID capture must present the next pc of the expected stream.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                check("load_flush_exclusive", 32'(ifid_load & ifid_flush), 0);
                if (!if_valid) begin
                    check("nop_when_empty", if_inst, NOP);
                end
                if (ifid_load) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL load_unexpected: got pc %h expected no capture", if_pc);
                    end else begin
                        e = exp_q.pop_front();
                        check("sb_if_pc", if_pc, e);
                        check("sb_if_inst", if_inst, word(e));
                        check("sb_if_pc4", if_pc4, e + 32'd4);
                        exp_q.push_back(e + 32'd4);
                        delivered++;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit seen;

        exp_q.push_back(RST_PC);
        repeat (2) cyc(0, 0, 0);
        check("rst_imem_req", 32'(imem_req), 0);
        check("rst_imem_addr", imem_addr, RST_PC);
        check("rst_if_valid", 32'(if_valid), 0);
        check("rst_if_inst", if_inst, NOP);
        check("rst_if_pc", if_pc, RST_PC);
        check("rst_if_pc4", if_pc4, RST_PC + 32'd4);
        check("rst_ifid_load", 32'(ifid_load), 0);
        check("rst_ifid_flush", 32'(ifid_flush), 0);

        // First fetch with a 1-cycle memory
        rel = 1'b1;
        lat = 1;
        cyc(0, 0, 0);
        check("c1_imem_req", 32'(imem_req), 1);
        check("c1_imem_addr", imem_addr, 32'h0);
        cyc(0, 0, 0);
        check("c2_if_valid", 32'(if_valid), 0);
        cyc(0, 0, 0);
        check("c3_if_valid", 32'(if_valid), 1);
        check("c3_if_inst", if_inst, 32'h0050_0093);
        check("c3_if_pc", if_pc, 32'h0);
        check("c3_if_pc4", if_pc4, 32'h4);
        check("c3_ifid_load", 32'(ifid_load), 1);
        check("c3_overlap_req", 32'(imem_req), 1);
        check("c3_overlap_addr", imem_addr, 32'h4);
        cyc(0, 0, 0);

        // Stall held three cycles with a full buffer
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0);
            check("stall_ifid_load", 32'(ifid_load), 0);
            check("stall_no_req", 32'(imem_req), 0);
            check("stall_if_pc", if_pc, 32'h4);
            check("stall_if_valid", 32'(if_valid), 1);
        end
        cyc(0, 0, 0);
        check("unstall_load", 32'(ifid_load), 1);
        check("unstall_req", 32'(imem_req), 1);
        check("unstall_addr", imem_addr, 32'h8);
        cyc(0, 0, 0);

        // Redirect while a slow request is outstanding
        lat = 3;
        cyc(0, 0, 0);
        check("pre_drop_addr", imem_addr, 32'hC);
        cyc(0, 1, 32'h100);
        check("drop_flush", 32'(ifid_flush), 1);
        check("drop_no_load", 32'(ifid_load), 0);
        check("drop_addr_now", imem_addr, 32'hC);
        cyc(0, 0, 0);
        check("drop_req_held", 32'(imem_req), 1);
        check("drop_addr_held", imem_addr, 32'hC);
        check("drop_if_valid", 32'(if_valid), 0);
        cyc(0, 0, 0);
        check("drop_rsp_addr", imem_addr, 32'hC);
        lat = 1;
        cyc(0, 0, 0);
        check("after_drop_req", 32'(imem_req), 1);
        check("after_drop_addr", imem_addr, 32'h100);

        // Redirect in the same cycle as the response
        cyc(0, 1, 32'h200);
        check("same_cyc_flush", 32'(ifid_flush), 1);
        cyc(0, 0, 0);
        check("same_cyc_if_valid", 32'(if_valid), 0);
        check("same_cyc_req", 32'(imem_req), 1);
        check("same_cyc_addr", imem_addr, 32'h200);
        cyc(0, 0, 0);

        // Redirect together with stall
        cyc(1, 1, 32'h300);
        check("rs_flush", 32'(ifid_flush), 1);
        check("rs_no_load", 32'(ifid_load), 0);
        lat = 3;
        cyc(0, 0, 0);
        check("rs_if_valid", 32'(if_valid), 0);
        check("rs_req", 32'(imem_req), 1);
        check("rs_addr", imem_addr, 32'h300);
        cyc(0, 0, 0);
        check("mid_req", 32'(imem_req), 1);

        // Reset asserted mid-request, then a stale response after release
        rel = 1'b0;
        @(negedge clk);
        rst  = 1'b0;
        pend = 1'b0;
        exp_q.delete();
        exp_q.push_back(RST_PC);
        #1;
        check("arst_imem_req", 32'(imem_req), 0);
        check("arst_imem_addr", imem_addr, RST_PC);
        check("arst_if_valid", 32'(if_valid), 0);
        check("arst_if_inst", if_inst, NOP);
        check("arst_ifid_flush", 32'(ifid_flush), 0);
        lat      = 1;
        force_rv = 1'b1;
        cyc(0, 0, 0);
        rel = 1'b1;
        cyc(0, 0, 0);
        force_rv = 1'b0;
        check("restart_req", 32'(imem_req), 1);
        check("restart_addr", imem_addr, RST_PC);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        check("restart_if_pc", if_pc, RST_PC);
        check("restart_if_inst", if_inst, word(RST_PC));
        check("restart_load", 32'(ifid_load), 1);

        // pc+4 wraps at the top of the address space
        cyc(0, 1, 32'hFFFF_FFFC);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cyc(0, 0, 0);
            if (ifid_load) begin
                seen = 1'b1;
                check("wrap_if_pc", if_pc, 32'hFFFF_FFFC);
                check("wrap_if_pc4", if_pc4, 32'h0);
            end
        end
        check("wrap_seen", 32'(seen), 1);
        repeat (4) cyc(0, 0, 0);

        // Randomized stall/redirect/latency mix
        rand_lat = 1'b1;
        base = delivered;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] tgt;
            tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'h0000_FFFC);
            cyc($urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0, tgt);
        end
        repeat (10) cyc(0, 0, 0);
        check("random_progress", 32'(delivered - base >= 200), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
